// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU cluster, the result buffer and its consumer.
// slave = the buffer itself; master = the producer/consumer side.
interface alu_result_buffer_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] i_result;
   logic             i_z;
   logic             i_v;
   logic             i_n;
   logic             i_cmp;
   logic [2:0]       i_alufn;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] o_result;
   logic [3:0]       o_flags;
   logic [2:0]       o_alufn;
   logic             o_valid;
   logic             i_ready;
   logic             i_clr;
   logic             o_sticky_v;
   logic [CNT_W-1:0] o_cmp_count;

   modport slave (
      input  i_result, i_z, i_v, i_n, i_cmp, i_alufn, i_valid, i_ready, i_clr,
      output o_ready, o_result, o_flags, o_alufn, o_valid, o_sticky_v, o_cmp_count
   );

   modport master (
      output i_result, i_z, i_v, i_n, i_cmp, i_alufn, i_valid, i_ready, i_clr,
      input  o_ready, o_result, o_flags, o_alufn, o_valid, o_sticky_v, o_cmp_count
   );
endinterface

// File: rtl/alu_result_buffer.sv
// Two-entry registered FIFO behind the adder/zvn/compare cluster, plus a sticky
// overflow flag and a saturating true-compare counter for debug readout.
module alu_result_buffer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input logic               clk,
   input logic               rst,
   alu_result_buffer_if.slave bus
);
   // Entry layout: {result, cmp, z, v, n, alufn}
   localparam int ENTRY_W = WIDTH + 7;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       count_reg;
   logic [1:0]       count_next;
   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic             sticky_v_reg;
   logic             sticky_v_next;
   logic [CNT_W-1:0] cmp_count_reg;
   logic [CNT_W-1:0] cmp_count_next;

   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic               cmp_inc;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head_entry;

   // o_ready depends only on registered occupancy, never on i_ready.
   assign full    = (count_reg == 2'd2);
   assign empty   = (count_reg == 2'd0);
   assign push    = bus.i_valid & ~full;
   assign pop     = ~empty & bus.i_ready;
   assign cmp_inc = push & bus.i_alufn[0] & bus.i_cmp;

   assign wr_entry = {bus.i_result, bus.i_cmp, bus.i_z, bus.i_v, bus.i_n, bus.i_alufn};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gen_entry
         logic [ENTRY_W-1:0] entry_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               entry_reg <= '0;
            end else if (push && (wr_ptr_reg == gi[0])) begin
               entry_reg <= wr_entry;
            end
         end
      end
   endgenerate

   assign head_entry = rd_ptr_reg ? gen_entry[1].entry_reg : gen_entry[0].entry_reg;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 2'd1;
         2'b01:   count_next = count_reg - 2'd1;
         default: count_next = count_reg;
      endcase
   end

   // A setting push beats a same-cycle clear for both debug registers.
   always_comb begin
      sticky_v_next = sticky_v_reg;
      if (bus.i_clr) begin
         sticky_v_next = 1'b0;
      end
      if (push && bus.i_v) begin
         sticky_v_next = 1'b1;
      end
   end

   always_comb begin
      cmp_count_next = cmp_count_reg;
      if (bus.i_clr) begin
         cmp_count_next = cmp_inc ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      end else if (cmp_inc && (cmp_count_reg != CNT_MAX)) begin
         cmp_count_next = cmp_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg     <= 2'd0;
         wr_ptr_reg    <= 1'b0;
         rd_ptr_reg    <= 1'b0;
         sticky_v_reg  <= 1'b0;
         cmp_count_reg <= '0;
      end else begin
         count_reg     <= count_next;
         sticky_v_reg  <= sticky_v_next;
         cmp_count_reg <= cmp_count_next;
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
      end
   end

   assign bus.o_ready     = ~full;
   assign bus.o_valid     = ~empty;
   assign bus.o_result    = head_entry[ENTRY_W-1 -: WIDTH];
   assign bus.o_flags     = head_entry[6:3];
   assign bus.o_alufn     = head_entry[2:0];
   assign bus.o_sticky_v  = sticky_v_reg;
   assign bus.o_cmp_count = cmp_count_reg;
endmodule
